// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART transmit queue.
package uart_pkg;

    localparam int unsigned UART_DEPTH_DEFAULT       = 16;
    localparam int unsigned UART_ACK_TIMEOUT_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO: power-of-two storage with free-running wrapping pointers and
// an occupancy counter. Full/empty come from the registered counter only.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = UART_DEPTH_DEFAULT
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push_i,
    input  logic [7:0]               wr_data_i,
    input  logic                     pop_i,
    output logic [7:0]               rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    // A push is refused when full, even if a pop happens in the same cycle.
    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign push_ok   = push_i && !full_o;
    assign pop_ok    = pop_i && !empty_o;
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and counter registers; reset empties the queue.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written on accepted pushes; no reset so it maps to RAM.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit queue placed directly upstream of a UART transmitter: buffers
// bytes and hands them one at a time to the transmitter with a START pulse,
// waiting for its TX_ACTIVE handshake and flagging a missing acknowledge.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = UART_DEPTH_DEFAULT,
    parameter int unsigned ACK_TIMEOUT = UART_ACK_TIMEOUT_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   WR_VALID,
    input  logic [7:0]             WR_DATA,
    output logic                   WR_READY,
    output logic                   START,
    output logic [7:0]             TX_DATA,
    input  logic                   TX_ACTIVE,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   EMPTY,
    output logic                   FULL,
    output logic                   TIMEOUT_ERR
);

    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    tx_state_e     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          err_q, err_d;
    logic          pop;
    logic [7:0]    head_data;
    logic          fifo_full;
    logic          fifo_empty;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push_i    (WR_VALID),
        .wr_data_i (WR_DATA),
        .pop_i     (pop),
        .rd_data_o (head_data),
        .count_o   (COUNT),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign FULL        = fifo_full;
    assign EMPTY       = fifo_empty;
    assign WR_READY    = !fifo_full;
    assign START       = (state_q == LOAD);
    assign TX_DATA     = tx_data_q;
    assign TIMEOUT_ERR = err_q;

    // Control FSM. The acknowledge window counts the START cycle itself, so
    // with ACK_TIMEOUT=4 the error flag shows four cycles after START.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        tx_data_d = tx_data_q;
        err_d     = err_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    tx_data_d = head_data;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                timer_d = TW'(1);
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (TX_ACTIVE) begin
                    state_d = WAIT_DONE;
                end else if (timer_q >= TW'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!TX_ACTIVE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, acknowledge timer, output byte register and sticky error flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            tx_data_q <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            tx_data_q <= tx_data_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a behavioural transmitter model.
module tb_uart_tx_queue;

    localparam int DEPTH       = 16;
    localparam int ACK_TIMEOUT = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       WR_VALID = 1'b0;
    logic [7:0] WR_DATA = 8'h00;
    logic       WR_READY;
    logic       START;
    logic [7:0] TX_DATA;
    logic       TX_ACTIVE = 1'b0;
    logic [4:0] COUNT;
    logic       EMPTY;
    logic       FULL;
    logic       TIMEOUT_ERR;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // transmitter model controls
    logic tx_auto = 1'b1;
    logic tx_hold = 1'b0;
    int   tx_len  = 100;
    logic tx_pend = 1'b0;
    int   tx_cnt  = 0;

    // log of every START pulse
    int         start_cyc_q[$];
    logic [7:0] start_data_q[$];

    uart_tx_queue #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .WR_VALID    (WR_VALID),
        .WR_DATA     (WR_DATA),
        .WR_READY    (WR_READY),
        .START       (START),
        .TX_DATA     (TX_DATA),
        .TX_ACTIVE   (TX_ACTIVE),
        .COUNT       (COUNT),
        .EMPTY       (EMPTY),
        .FULL        (FULL),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // START monitor, sampled mid-cycle
    always @(negedge CLK) begin
        if (START === 1'b1) begin
            start_cyc_q.push_back(cyc);
            start_data_q.push_back(TX_DATA);
        end
    end

    // Transmitter: TX_ACTIVE high for tx_len cycles starting the cycle after START
    always @(negedge CLK) begin
        if (!RST) begin
            TX_ACTIVE = 1'b0;
            tx_pend   = 1'b0;
            tx_cnt    = 0;
        end else begin
            if (TX_ACTIVE && !tx_hold) begin
                tx_cnt = tx_cnt - 1;
                if (tx_cnt <= 0) TX_ACTIVE = 1'b0;
            end
            if (tx_pend) begin
                TX_ACTIVE = 1'b1;
                tx_cnt    = tx_len;
                tx_pend   = 1'b0;
            end
            if (START === 1'b1 && tx_auto) tx_pend = 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        WR_VALID = 1'b1;
        WR_DATA  = b;
        tick();
        WR_VALID = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget, input string tag);
        int b = budget;
        while (start_cyc_q.size() < n && b > 0) begin
            tick();
            b--;
        end
        check_eq(tag, start_cyc_q.size(), n);
    endtask

    // Returns in the first cycle the FSM spends in IDLE after a transmission.
    task automatic wait_tx_fall(input string tag);
        int b = 200;
        while (TX_ACTIVE !== 1'b1 && b > 0) begin
            tick();
            b--;
        end
        while (TX_ACTIVE !== 1'b0 && b > 0) begin
            tick();
            b--;
        end
        if (b == 0) check_eq(tag, TX_ACTIVE, 1'b0);
    endtask

    function automatic logic [7:0] logged_data(input int idx);
        if (idx < start_data_q.size()) return start_data_q[idx];
        return 8'hxx;
    endfunction

    function automatic int logged_cyc(input int idx);
        if (idx < start_cyc_q.size()) return start_cyc_q[idx];
        return -1;
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_count"},    COUNT, 5'd0);
        check_eq({pfx, "_empty"},    EMPTY, 1'b1);
        check_eq({pfx, "_full"},     FULL, 1'b0);
        check_eq({pfx, "_wr_ready"}, WR_READY, 1'b1);
        check_eq({pfx, "_start"},    START, 1'b0);
        check_eq({pfx, "_tx_data"},  TX_DATA, 8'h00);
        check_eq({pfx, "_timeout"},  TIMEOUT_ERR, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int w;
        int s;
        int n0;

        #2 RST = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        RST  = 1'b1;
        base = cyc;

        // ---- single byte 0x41 written at cycle 10
        tx_auto = 1'b1;
        tx_len  = 100;
        while (cyc < base + 10) tick();
        w = cyc;
        push_byte(8'h41);
        wait_starts(1, 10, "t1_start_seen");
        check_eq("t1_start_cycle", logged_cyc(0) - base, 12);
        check_eq("t1_tx_data", logged_data(0), 8'h41);
        repeat (130) tick();
        check_eq("t1_single_start", start_cyc_q.size(), 1);
        check_eq("t1_empty", EMPTY, 1'b1);

        // ---- burst of 16 while transmitter is held busy, 17th dropped
        tx_len  = 3;
        tx_hold = 1'b1;
        push_byte(8'hA0);
        wait_starts(2, 10, "t2_sentinel_start");
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        check_eq("t2_full", FULL, 1'b1);
        check_eq("t2_count16", COUNT, 5'd16);
        check_eq("t2_wr_ready", WR_READY, 1'b0);
        push_byte(8'hFF);
        check_eq("t2_count_after_drop", COUNT, 5'd16);
        tx_hold = 1'b0;
        wait_starts(18, 400, "t2_all_started");
        repeat (20) tick();
        check_eq("t2_no_extra_start", start_cyc_q.size(), 18);
        for (int i = 0; i < 16; i++)
            check_eq($sformatf("t2_order_%0d", i), logged_data(2 + i), 32'(i));
        check_eq("t2_b2b_spacing", logged_cyc(4) - logged_cyc(3), tx_len + 3);
        check_eq("t2_empty_end", EMPTY, 1'b1);

        // ---- steady state at COUNT=8 with simultaneous push and pop
        tx_hold = 1'b1;
        push_byte(8'hA5);
        wait_starts(19, 10, "t3_sentinel_start");
        for (int i = 0; i < 8; i++) push_byte(8'h80 + 8'(i));
        check_eq("t3_count8_fill", COUNT, 5'd8);
        tx_hold = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wait_tx_fall($sformatf("t3_fall_timeout_%0d", i));
            push_byte(8'h88 + 8'(i));
            check_eq($sformatf("t3_count8_%0d", i), COUNT, 5'd8);
        end
        wait_starts(19 + 48, 600, "t3_all_started");
        check_eq("t3_sentinel_data", logged_data(18), 8'hA5);
        for (int i = 0; i < 48; i++)
            check_eq($sformatf("t3_order_%0d", i), logged_data(19 + i), 32'(8'h80 + i));
        repeat (10) tick();
        check_eq("t3_empty_end", EMPTY, 1'b1);

        // ---- acknowledge timeout with TX_ACTIVE stuck low
        tx_auto = 1'b0;
        n0 = start_cyc_q.size();
        push_byte(8'h55);
        wait_starts(n0 + 1, 10, "t4_start_seen");
        s = logged_cyc(n0);
        check_eq("t4_tx_data", logged_data(n0), 8'h55);
        while (cyc < s + 3) tick();
        check_eq("t4_err_not_yet", TIMEOUT_ERR, 1'b0);
        tick();
        check_eq("t4_err_set", TIMEOUT_ERR, 1'b1);
        check_eq("t4_single_start", start_cyc_q.size(), n0 + 1);
        tx_auto = 1'b1;
        push_byte(8'h66);
        wait_starts(n0 + 2, 10, "t4_next_start");
        check_eq("t4_next_data", logged_data(n0 + 1), 8'h66);
        check_eq("t4_next_cycle", logged_cyc(n0 + 1) - s, 6);
        check_eq("t4_err_sticky", TIMEOUT_ERR, 1'b1);
        repeat (10) tick();

        // ---- reset during WAIT_DONE with five bytes queued
        tx_hold = 1'b1;
        n0 = start_cyc_q.size();
        push_byte(8'hC0);
        wait_starts(n0 + 1, 10, "t5_sentinel_start");
        for (int i = 0; i < 5; i++) push_byte(8'hD1 + 8'(i));
        check_eq("t5_count5", COUNT, 5'd5);
        check_eq("t5_tx_data_pre", TX_DATA, 8'hC0);
        repeat (2) tick();
        #2 RST = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        tx_hold = 1'b0;
        repeat (2) tick();
        RST = 1'b1;
        repeat (12) tick();
        check_eq("t5_no_start_after", start_cyc_q.size(), n0 + 1);
        check_eq("t5_empty_after", EMPTY, 1'b1);
        push_byte(8'h77);
        wait_starts(n0 + 2, 10, "t5_new_start");
        check_eq("t5_new_data", logged_data(n0 + 1), 8'h77);
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >= 2).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 4, max cycles to wait for TX_ACTIVE to rise after START.
REQ-003 SHALL have port CLK  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port WR_VALID  input  1  producer offers WR_DATA.
REQ-006 SHALL have port WR_DATA  input  8  byte to queue.
REQ-007 SHALL have port WR_READY  output  1  queue can accept a byte; equals !FULL.
REQ-008 SHALL have port START  output  1  one-cycle pulse that starts the downstream UART transmitter.
REQ-009 SHALL have port TX_DATA  output  8  byte presented to the transmitter; valid while START is high and held until the next START.
REQ-010 SHALL have port TX_ACTIVE  input  1  transmitter busy indication.
REQ-011 SHALL have port COUNT  output  $clog2(DEPTH)+1  bytes currently stored.
REQ-012 SHALL have ports EMPTY and FULL  output  1 each  COUNT==0 and COUNT==DEPTH.
REQ-013 SHALL have port TIMEOUT_ERR  output  1  sticky flag: TX_ACTIVE never rose within ACK_TIMEOUT.

Function
REQ-014 SHALL push WR_DATA in any cycle where WR_VALID && WR_READY; WR_VALID while FULL is ignored and the byte is dropped.
REQ-015 SHALL run a control FSM with states IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-016 IDLE -> LOAD when !EMPTY; the head byte is popped into the TX_DATA register on this edge.
REQ-017 LOAD SHALL assert START for exactly one cycle, then go to WAIT_BUSY unconditionally.
REQ-018 WAIT_BUSY -> WAIT_DONE when TX_ACTIVE==1; after ACK_TIMEOUT cycles without TX_ACTIVE it SHALL set TIMEOUT_ERR and go to IDLE.
REQ-019 WAIT_DONE -> IDLE when TX_ACTIVE==0.
REQ-020 A byte written into an empty idle queue in cycle N SHALL produce START in cycle N+2.
REQ-021 Back-to-back bytes SHALL start no earlier than 2 cycles after TX_ACTIVE falls (WAIT_DONE -> IDLE -> LOAD).
REQ-022 A simultaneous push and pop SHALL leave COUNT unchanged and both operations take effect; when FULL, the push is refused even if a pop occurs in the same cycle.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH with no lost or duplicated byte; bytes SHALL leave in write order.
REQ-024 COUNT, EMPTY, FULL and WR_READY SHALL be registered-state derived, with no combinational path from WR_VALID.
REQ-025 START SHALL never be asserted outside LOAD; TX_DATA SHALL only change on the IDLE -> LOAD edge.
REQ-026 TIMEOUT_ERR SHALL clear only on reset.

Reset
REQ-027 On RST low, asynchronously: state IDLE, pointers and COUNT 0, EMPTY 1, FULL 0, WR_READY 1, START 0, TX_DATA 8'h00, TIMEOUT_ERR 0.
REQ-028 Reset mid-transmission SHALL discard all queued bytes; START SHALL not be issued for at least 1 cycle after release.

Structure
REQ-029 The FSM state enum and the default DEPTH/ACK_TIMEOUT constants SHALL live in shared package uart_pkg.
REQ-030 Storage and pointers SHALL be a sub-module uart_byte_fifo (push/pop/count/full/empty); the FSM stays in uart_tx_queue.
REQ-031 The intended instantiation is directly upstream of uart_tx: START -> START, TX_DATA -> TX_DATA_IN, TX_ACTIVE <- TX_ACTIVE.

Verification
REQ-032 Single byte 8'h41 written at cycle 10 into an empty queue -> START at cycle 12 with TX_DATA=8'h41; the model raises TX_ACTIVE at cycle 13 for 100 cycles; IDLE follows and there is no further START.
REQ-033 Burst of 16 bytes 8'h00..8'h0F in consecutive cycles -> FULL after the 16th byte; a 17th byte 8'hFF is dropped; output order is 00..0F; EMPTY at the end.
REQ-034 Keep the queue at COUNT=8 with push and pop in the same cycle for 40 bytes -> COUNT stays 8, pointers wrap at least twice, and the data order is intact.
REQ-035 TX_ACTIVE tied 0 with byte 8'h55 queued -> START pulses once, TIMEOUT_ERR=1 four cycles later, and the next queued byte still issues START.
REQ-036 Assert RST low in the middle of WAIT_DONE with COUNT=5 -> all outputs reach their reset values immediately and no START is issued after release until a new write.
